fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the unified memory's instruction port.
- Owns the program counter and drives the memory's ReadPC.
- Captures the memory's registered Instr response one cycle after each request.
- Buffers fetched words in a small queue and presents {PC, instruction} to decode through a valid/ready handshake.
- Handles branch redirects, cancelling in-flight and buffered fetches.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 55 +++++
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and types for the instruction-fetch stage and its buffer.
package fetch_pkg;

  localparam int          DEFAULT_PC_W      = 32;
  localparam int          DEFAULT_BUF_DEPTH = 2;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam int          INSTR_W           = 32;

  typedef struct packed {
    logic [DEFAULT_PC_W-1:0] pc;
    logic [INSTR_W-1:0]      instr;
  } fetch_entry_t;

  // Count must hold 0..depth inclusive, so it needs one more code than a pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush wins over push.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = DEFAULT_BUF_DEPTH
) (
  input  logic                          clk,
  input  logic                          flush,
  input  logic                          push,
  input  logic                          pop,
  input  entry_t                        din,
  output entry_t                        head,
  output logic                          valid,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = count_width(DEPTH);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               full;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign valid = (count != '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = valid ? mem[rd_ptr] : '0;

  assert property (@(posedge clk) disable iff (flush) !(push && full && !pop));
  assert property (@(posedge clk) disable iff (flush) !(pop && !valid));
  assert property (@(posedge clk) !(full && !valid));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, tracks the one-cycle memory response and
// feeds decode through a small buffer with valid/ready and branch redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W      = DEFAULT_PC_W,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEFAULT_RESET_PC),
  parameter int              BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
  input  logic               Clk,
  input  logic               Clear,
  output logic [PC_W-1:0]    ReadPC,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               IfReady,
  output logic               IfValid,
  output logic [INSTR_W-1:0] IfInstr,
  output logic [PC_W-1:0]    IfPC,
  input  logic               BranchEn,
  input  logic [PC_W-1:0]    BranchTarget
);

  localparam int CNT_W = count_width(BUF_DEPTH);

  // Local entry type so a non-default PC_W still packs correctly.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  inflight_pc;
  logic             inflight;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;
  logic             flush;
  logic             issue;
  entry_t           head;
  entry_t           push_entry;

  assign pop        = IfValid & IfReady;
  assign flush      = Clear | BranchEn;
  assign push       = inflight & ~flush;
  assign push_entry = '{pc: inflight_pc, instr: Instr};

  // Occupancy counts the word still on its way back so the buffer can never overflow.
  assign issue = ~Clear & ~BranchEn &
                 ((int'(count) + int'(inflight) - int'(pop)) < BUF_DEPTH);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (BranchEn) begin
      pc       <= BranchTarget;
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= pc + 1'b1;
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_buffer #(
    .entry_t (entry_t),
    .DEPTH   (BUF_DEPTH)
  ) u_buffer (
    .clk   (Clk),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .valid (IfValid),
    .count (count)
  );

  assign ReadPC  = pc;
  assign IfPC    = head.pc;
  assign IfInstr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model plus a scoreboard of the
// {pc, instr} stream decode should see, refilled on every Clear or redirect.
module tb_fetch_unit;

  logic        Clk;
  logic        Clear;
  logic [31:0] ReadPC;
  logic [31:0] Instr;
  logic        IfReady;
  logic        IfValid;
  logic [31:0] IfInstr;
  logic [31:0] IfPC;
  logic        BranchEn;
  logic [31:0] BranchTarget;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  fetch_unit dut (
    .Clk          (Clk),
    .Clear        (Clear),
    .ReadPC       (ReadPC),
    .Instr        (Instr),
    .IfReady      (IfReady),
    .IfValid      (IfValid),
    .IfInstr      (IfInstr),
    .IfPC         (IfPC),
    .BranchEn     (BranchEn),
    .BranchTarget (BranchTarget)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'd8) ? 32'h100 + a : {a[15:0], ~a[15:0]};
  endfunction

  // Registered memory: address in cycle t, data in cycle t+1.
  always @(posedge Clk) Instr <= mem_word(ReadPC);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_seg(input logic [31:0] start);
    logic [31:0] a;
    sb.delete();
    for (int i = 0; i < 40; i++) begin
      a = start + 32'(i);
      sb.push_back('{pc: a, instr: mem_word(a)});
    end
  endtask

  // Called at a negedge with inputs already driven: score the handshake of this
  // cycle, restart the expected stream on Clear/redirect, then advance one cycle.
  task automatic cycle();
    exp_t e;
    if (IfValid && IfReady) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check("stream_pc", IfPC, e.pc);
        check("stream_instr", IfInstr, e.instr);
      end
    end
    if (Clear)         push_seg(32'h0);
    else if (BranchEn) push_seg(BranchTarget);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    Clear        = 1'b1;
    IfReady      = 1'b1;
    BranchEn     = 1'b0;
    BranchTarget = 32'h0;
    @(negedge Clk);
    repeat (3) cycle();
    check("reset_valid", IfValid, 0);
    check("reset_readpc", ReadPC, 0);
    check("reset_ifpc", IfPC, 0);
    check("reset_ifinstr", IfInstr, 0);

    // Startup latency and streaming.
    Clear = 1'b0;
    check("start_readpc", ReadPC, 0);
    cycle();
    check("lat1_valid", IfValid, 0);
    cycle();
    check("lat2_valid", IfValid, 1);
    check("lat2_pc", IfPC, 0);
    check("lat2_instr", IfInstr, 32'h100);
    repeat (3) cycle();
    check("bp_head_before", IfPC, 3);

    // Backpressure: head, instruction and fetch address all hold.
    IfReady = 1'b0;
    repeat (5) begin
      cycle();
      check("bp_valid", IfValid, 1);
      check("bp_head", IfPC, 3);
      check("bp_instr", IfInstr, 32'h103);
      check("bp_readpc", ReadPC, 5);
    end
    IfReady = 1'b1;
    repeat (4) begin
      cycle();
      check("resume_valid", IfValid, 1);
    end

    // Redirect with one word buffered and one in flight, decode stalled.
    IfReady      = 1'b0;
    BranchEn     = 1'b1;
    BranchTarget = 32'h40;
    cycle();
    BranchEn = 1'b0;
    IfReady  = 1'b1;
    check("br_valid_b1", IfValid, 0);
    check("br_readpc_b1", ReadPC, 32'h40);
    cycle();
    check("br_valid_b2", IfValid, 0);
    cycle();
    check("br_valid_b3", IfValid, 1);
    check("br_pc_b3", IfPC, 32'h40);
    repeat (3) cycle();

    // Redirect to 2 concurrent with a handshake, then stream up to head 5.
    BranchEn     = 1'b1;
    BranchTarget = 32'h2;
    cycle();
    BranchEn = 1'b0;
    repeat (2) cycle();
    check("br2_pc", IfPC, 2);
    repeat (3) cycle();
    check("brrdy_head", IfPC, 5);

    // Redirect while decode takes head 5: 5 is consumed, target follows.
    BranchEn     = 1'b1;
    BranchTarget = 32'h80;
    cycle();
    BranchEn = 1'b0;
    check("brrdy_valid_b1", IfValid, 0);
    repeat (2) cycle();
    check("brrdy_pc_b3", IfPC, 32'h80);
    repeat (2) cycle();

    // Back-to-back redirects: the last one wins.
    BranchEn     = 1'b1;
    BranchTarget = 32'h10;
    cycle();
    BranchTarget = 32'h20;
    cycle();
    BranchEn = 1'b0;
    check("b2b_valid_b1", IfValid, 0);
    repeat (2) cycle();
    check("b2b_valid_b3", IfValid, 1);
    check("b2b_pc_b3", IfPC, 32'h20);
    repeat (2) cycle();

    // Clear with a full buffer and a concurrent redirect; Clear wins.
    IfReady = 1'b0;
    repeat (2) cycle();
    Clear        = 1'b1;
    BranchEn     = 1'b1;
    BranchTarget = 32'h99;
    cycle();
    Clear    = 1'b0;
    BranchEn = 1'b0;
    IfReady  = 1'b1;
    check("clr_valid", IfValid, 0);
    check("clr_ifpc", IfPC, 0);
    check("clr_ifinstr", IfInstr, 0);
    check("clr_readpc", ReadPC, 0);
    cycle();
    check("clr_valid_1", IfValid, 0);
    cycle();
    check("clr_valid_2", IfValid, 1);
    check("clr_pc_2", IfPC, 0);
    repeat (2) cycle();

    // PC wrap at the top of the address space.
    BranchEn     = 1'b1;
    BranchTarget = 32'hFFFF_FFFF;
    cycle();
    BranchEn = 1'b0;
    repeat (2) cycle();
    check("wrap_pc_hi", IfPC, 32'hFFFF_FFFF);
    cycle();
    check("wrap_pc_lo", IfPC, 32'h0);
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
